uart_tx: RTL and testbench

Serial transmitter for the 8N1 UART link: accepts bytes from user logic through a valid/ready handshake and shifts them out LSB-first on the TX line. Each bit lasts `BAUD_MULT` clock cycles. A one-entry holding register lets the next byte be queued while the current frame is on the wire, so back-to-back frames have no idle gap. It sits on the TX pin, opposite the board-level `uart_rx`, and shares its clock and baud scheme.

---
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8-bit UART transmitter, LSB first, 1 or 2 stop bits. A one-byte holding
// register lets the next byte queue behind the frame on the wire, so consecutive frames leave no idle gap.
module uart_tx #(
  parameter int unsigned BAUD_MULT = 139,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       i_uart_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_data,
  output logic       o_tx_active,
  output logic       o_tx_done,
  output logic       o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  localparam logic [15:0] CNT_LAST  = 16'(BAUD_MULT - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic        stop_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        tx_data_q, tx_active_q, tx_done_q;

  logic accept;
  logic bit_end;
  logic frame_last;
  logic load;

  assign o_tx_ready  = !hold_valid_q && i_rst_n;
  assign o_tx_data   = tx_data_q;
  assign o_tx_active = tx_active_q;
  assign o_tx_done   = tx_done_q;
  assign o_dbg_state = (state_q == ST_IDLE);

  assign accept     = i_tx_valid && o_tx_ready;
  assign bit_end    = (cnt_q == CNT_LAST);
  assign frame_last = (state_q == ST_STOP) && bit_end && (stop_idx_q == STOP_LAST);
  assign load       = hold_valid_q && ((state_q == ST_IDLE) || frame_last);

  // Accept and load never coincide: accepting needs an empty holding register, loading needs a full one.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (load) begin
      hold_valid_d = 1'b0;
    end
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_d       = i_tx_byte;
    end
  end

  always_ff @(posedge i_uart_clk) begin
    if (!i_rst_n) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end

  always_ff @(posedge i_uart_clk) begin
    // NOTE: state registers use non-blocking assignments, so every read in this block sees the pre-edge value.
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      tx_data_q   <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (state_q != ST_IDLE) begin
        cnt_q <= bit_end ? 16'd0 : cnt_q + 16'd1;
      end

      case (state_q)
        ST_IDLE: begin
          tx_data_q <= 1'b1;
          if (hold_valid_q) begin
            shift_q     <= hold_q;
            cnt_q       <= '0;
            tx_data_q   <= 1'b0;
            tx_active_q <= 1'b1;
            state_q     <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            tx_data_q <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              tx_data_q  <= 1'b1;
              stop_idx_q <= 1'b0;
              state_q    <= ST_STOP;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_data_q <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            if (stop_idx_q == STOP_LAST) begin
              tx_done_q <= 1'b1;
              // A queued byte starts its start bit straight after the last stop bit.
              if (hold_valid_q) begin
                shift_q   <= hold_q;
                tx_data_q <= 1'b0;
                state_q   <= ST_START;
              end else begin
                tx_active_q <= 1'b0;
                state_q     <= ST_IDLE;
              end
            end else begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          tx_data_q   <= 1'b1;
          tx_active_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (BAUD_MULT/STOP_BITS = 4/1, 3/2, 139/1),
// each with its own driver and a line-level monitor that rebuilds every frame from queued bytes.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit inst_done [3];

  task automatic check(input int inst, input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL u%0d %s: got %0d want %0d at t=%0t", inst, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int BM    = (g == 0) ? 4 : (g == 1) ? 3 : 139;
    localparam int SB    = (g == 1) ? 2 : 1;
    localparam int FRAME = (9 + SB) * BM;
    localparam int NRAND = (g == 2) ? 2 : 12;
    localparam logic [7:0] FIRST = (g == 0) ? 8'h55 : (g == 1) ? 8'h80 : 8'h0D;

    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic       ready, line, active, done, dbg;
    logic [7:0] exp_q [$];

    uart_tx #(.BAUD_MULT(BM), .STOP_BITS(SB)) u_dut (
      .i_uart_clk (clk),
      .i_rst_n    (rst_n),
      .i_tx_byte  (data),
      .i_tx_valid (valid),
      .o_tx_ready (ready),
      .o_tx_data  (line),
      .o_tx_active(active),
      .o_tx_done  (done),
      .o_dbg_state(dbg)
    );

    // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
    task automatic send(input logic [7:0] b);
      int n = 0;
      valid = 1'b1;
      while (!ready && n < 4 * FRAME) begin
        data = 8'($urandom);
        @(negedge clk);
        n++;
      end
      if (!ready) begin
        check(g, "send_ready", int'(ready), 1);
        valid = 1'b0;
      end else begin
        data = b;
        @(posedge clk);
        exp_q.push_back(b);
        @(negedge clk);
      end
    endtask

    task automatic wait_idle();
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while ((active || !ready) && n < 4 * FRAME);
      check(g, "idle_reached", int'(!active && ready), 1);
      repeat (2) @(negedge clk);
    endtask

    initial begin : drv
      rst_n = 1'b0;
      valid = 1'b0;
      data  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      send(FIRST);
      valid = 1'b0;
      wait_idle();

      send(8'hA5);
      send(8'h3C);
      valid = 1'b0;
      wait_idle();

      send(8'h01);
      send(8'h02);
      send(8'h03);
      valid = 1'b0;
      wait_idle();

      for (int i = 0; i < NRAND; i++) begin
        send(8'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
      valid = 1'b0;
      wait_idle();

      // Reset in the middle of data bit 3 of 0xFF with a second byte already held.
      send(8'hFF);
      send(8'($urandom));
      valid = 1'b0;
      repeat (4 * BM + BM / 2 - 1) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * FRAME) @(negedge clk);

      send(8'h5A);
      valid = 1'b0;
      wait_idle();
      check(g, "queue_drained", exp_q.size(), 0);
      inst_done[g] = 1'b1;
    end

    initial begin : mon
      bit         in_frame;
      bit         done_due;
      bit         start_due;
      bit         act;
      int         k;
      int         bi;
      logic       lvl;
      logic [7:0] cur;
      logic [7:0] dec;
      in_frame  = 1'b0;
      done_due  = 1'b0;
      start_due = 1'b0;
      k         = 0;
      cur       = '0;
      dec       = '0;
      forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
          check(g, "rst_line", int'(line), 1);
          check(g, "rst_active", int'(active), 0);
          check(g, "rst_done", int'(done), 0);
          check(g, "rst_ready", int'(ready), 0);
          check(g, "rst_dbg", int'(dbg), 1);
          in_frame  = 1'b0;
          done_due  = 1'b0;
          start_due = 1'b0;
          exp_q.delete();
        end else begin
          check(g, "done", int'(done), int'(done_due));
          done_due = 1'b0;
          if (!in_frame && line == 1'b0) begin
            check(g, "start_expected", int'(exp_q.size() != 0), 1);
            cur      = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            in_frame = 1'b1;
            k        = 0;
            dec      = '0;
          end
          if (start_due) check(g, "start_latency", int'(in_frame), 1);
          act = in_frame;
          if (in_frame) begin
            bi  = k / BM;
            lvl = (bi == 0) ? 1'b0 : (bi <= 8) ? cur[bi - 1] : 1'b1;
            check(g, "line", int'(line), int'(lvl));
            if (bi >= 1 && bi <= 8 && (k % BM) == BM / 2) dec[bi - 1] = line;
            k++;
            if (k == FRAME) begin
              check(g, "byte", int'(dec), int'(cur));
              in_frame = 1'b0;
              done_due = 1'b1;
            end
          end
          check(g, "active", int'(active), int'(act));
          check(g, "dbg_idle", int'(dbg), int'(!act));
          check(g, "ready", int'(ready), int'(exp_q.size() == 0));
          start_due = !in_frame && exp_q.size() != 0;
        end
      end
    end
  end

  initial begin : summary
    fork
      wait (inst_done[0] && inst_done[1] && inst_done[2]);
      #2000000;
    join_any
    disable fork;
    check(9, "all_instances_finished", int'(inst_done[0] && inst_done[1] && inst_done[2]), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
